mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares the single memory_controller request port among NUM_REQ compute/DMA requesters.
//  Round-robin arbitration with valid/ready handshake; routes read data back to the issuing requester.
//  Drives memory_controller bank_power_en: idle banks auto-power-down, 1-cycle wake on demand.
//  Sits between compute units and memory_controller.
// PARAMETERS
//  NUM_REQ       4    number of requesters (>=2)
//  BRAM_BANKS    19   banks behind memory_controller
//  BANK_W        5    bank-select width
//  ADDR_W        10   in-bank address width (BRAM_ADDR_WIDTH)
//  DATA_W        8    data width
//  RD_LATENCY    2    cycles from mc_re to mc_rvalid (memory_controller = 2)
//  IDLE_TIMEOUT  256  idle cycles before bank power-down; elaboration error if < RD_LATENCY+1
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 async active-low reset
//  req_valid    in   NUM_REQ           request valid per requester
//  req_ready    out  NUM_REQ           grant; transfer when valid&ready
//  req_we       in   NUM_REQ           1=write, 0=read
//  req_bank     in   NUM_REQ*BANK_W    bank select, requester i at [i*BANK_W +: BANK_W]
//  req_addr     in   NUM_REQ*ADDR_W    in-bank address
//  req_wdata    in   NUM_REQ*DATA_W    write data
//  rsp_valid    out  NUM_REQ           one-cycle read-data strobe to issuing requester
//  rsp_data     out  DATA_W            read data (shared bus, qualified by rsp_valid)
//  mc_we/mc_re  out  1/1               to memory_controller req.we/req.re
//  mc_bank      out  BANK_W            to req.bank_sel
//  mc_addr      out  ADDR_W            to req.addr
//  mc_wdata     out  DATA_W            to req.data
//  mc_rdata     in   DATA_W            from resp.data
//  mc_rvalid    in   1                 from resp.valid
//  bank_power_en out BRAM_BANKS        to memory_controller bank_power_en
//  err_rsp      out  1                 sticky: expected read response missing
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_data=0, mc_*=0, err_rsp=0, rr_ptr=0, read pipe empty.
//  - Eligible(i) = req_valid[i] & (req_bank[i]>=BRAM_BANKS | bank_power_en[bank]).
//    Out-of-range banks count as powered and pass through (mc returns 0x00).
//  - One grant per cycle: first eligible i searching from rr_ptr upward (mod NUM_REQ).
//    req_ready combinational from the grant; rr_ptr <= grant+1 on grant, else held.
//  - mc_* combinational from granted requester; no grant -> mc_we=mc_re=0, other mc_* = 0.
//  - Requesters hold valid and fields stable until ready; valid never drops before ready.
//  - Read route pipe: RD_LATENCY-deep shift of {vld,id}, pushed every cycle (vld=granted read).
//    At pipe output: if vld & mc_rvalid -> rsp_valid[id]=1, rsp_data=mc_rdata (comb, zero added latency).
//    Total read latency RD_LATENCY cycles after handshake; back-to-back reads fully pipelined.
//    If vld & !mc_rvalid, or mc_rvalid & !vld -> err_rsp set, held until reset.
//  - Writes produce no response; complete at handshake.
//  - Reset mid-operation clears the pipe; in-flight reads produce no response.
// CONFIGURATION
//  AUTO_POWERDOWN_EN defined:
//   - bank_power_en registered, reset 0; per-bank idle counter, reset 0.
//   - Wake: any req_valid to unpowered in-range bank -> bank_power_en[b]=1 next cycle;
//     counter<=IDLE_TIMEOUT. Grant possible that cycle (1-cycle wake penalty).
//     Multiple banks wake together; other eligible requesters are granted meanwhile.
//   - Granted access to bank b reloads counter<=IDLE_TIMEOUT.
//   - Else if powered: counter decrements; at 0, bank_power_en[b] cleared next cycle.
//   - Access and expiry in the same cycle: access wins, bank stays on.
//  AUTO_POWERDOWN_EN undefined: bank_power_en constant all-ones, no counters, no wake penalty.
// TESTING
//  1 Reset: rst_n low mid-read -> all outputs 0, no rsp_valid after release, err_rsp=0.
//  2 Req0-3 all valid reads, bank 2 powered -> grants 0,1,2,3,0 on consecutive cycles;
//    rsp_valid[i] exactly 2 cycles after each handshake with correct data.
//  3 Req1 write 0xA5 to bank 3 addr 0x010, then read -> rsp_valid[1] with rsp_data=0xA5.
//  4 (AUTO_POWERDOWN_EN) Reset, req0 read bank 5 -> power_en[5]=1 at +1, ready at +1;
//    after 256 idle cycles power_en[5] drops; access on expiry cycle keeps it on.
//  5 (AUTO_POWERDOWN_EN) Req0 -> bank 4 off, req1 -> bank 0 on -> req1 granted first, req0 a cycle later.
//  6 Req2 read bank 20 -> ready, rsp_valid[2] with 0x00 after 2 cycles; forced mc_rvalid=0 -> err_rsp=1.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side and memory_controller-side signals of mem_req_arbiter.
// master = requesters plus memory_controller response, slave = the arbiter.
interface mem_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BRAM_BANKS = 19,
    parameter int BANK_W     = 5,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*BANK_W-1:0] req_bank;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      mc_we;
    logic                      mc_re;
    logic [BANK_W-1:0]         mc_bank;
    logic [ADDR_W-1:0]         mc_addr;
    logic [DATA_W-1:0]         mc_wdata;
    logic [DATA_W-1:0]         mc_rdata;
    logic                      mc_rvalid;
    logic [BRAM_BANKS-1:0]     bank_power_en;
    logic                      err_rsp;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata, mc_rdata, mc_rvalid,
        input  req_ready, rsp_valid, rsp_data, mc_we, mc_re, mc_bank, mc_addr, mc_wdata,
               bank_power_en, err_rsp
    );
    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata, mc_rdata, mc_rvalid,
        output req_ready, rsp_valid, rsp_data, mc_we, mc_re, mc_bank, mc_addr, mc_wdata,
               bank_power_en, err_rsp
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of the memory_controller port with read-data routing.
// Define AUTO_POWERDOWN_EN for idle-bank power-down with a 1-cycle wake penalty.
module mem_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BRAM_BANKS   = 19,
    parameter int BANK_W       = 5,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 2,
    parameter int IDLE_TIMEOUT = 256
) (
    input logic              clk,
    input logic              rst_n,
    mem_req_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PW   = RD_LATENCY * ID_W;

    if (IDLE_TIMEOUT < RD_LATENCY + 1) begin : g_bad_timeout
        $error("IDLE_TIMEOUT must be at least RD_LATENCY+1");
    end

    logic [BRAM_BANKS-1:0]           pwr;
    logic [2**BANK_W-1:0]            pwr_all;
    logic [NUM_REQ-1:0]              elig;
    logic [ID_W-1:0]                 cand [NUM_REQ];
    logic                            gnt_vld;
    logic [ID_W-1:0]                 gnt_id;
    logic [BANK_W-1:0]               gnt_bank;
    logic [ID_W-1:0]                 rr_q, rr_d;
    logic [RD_LATENCY-1:0]           pv_q, pv_d;
    logic [RD_LATENCY-1:0][ID_W-1:0] pid_q, pid_d;
    logic                            hit;
    logic                            err_q, err_d;

    // Banks beyond BRAM_BANKS read as powered so out-of-range requests pass through.
    always_comb begin
        pwr_all = '1;
        pwr_all[BRAM_BANKS-1:0] = pwr;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = bus.req_valid[i] & pwr_all[bus.req_bank[i*BANK_W +: BANK_W]];
    end

    // Scanning from the far end lets the closest eligible requester to rr_q win last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++)
            cand[k] = ID_W'((int'(rr_q) + k) % NUM_REQ);
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[cand[k]] && rst_n) begin
                gnt_vld = 1'b1;
                gnt_id  = cand[k];
            end
        end
        gnt_bank      = bus.req_bank[int'(gnt_id)*BANK_W +: BANK_W];
        rr_d          = gnt_vld ? ((gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1) : rr_q;
        bus.req_ready = NUM_REQ'(gnt_vld) << gnt_id;
        bus.mc_we     = gnt_vld & bus.req_we[gnt_id];
        bus.mc_re     = gnt_vld & ~bus.req_we[gnt_id];
        bus.mc_bank   = gnt_vld ? gnt_bank : '0;
        bus.mc_addr   = gnt_vld ? bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W] : '0;
        bus.mc_wdata  = gnt_vld ? bus.req_wdata[int'(gnt_id)*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        pv_d          = RD_LATENCY'({pv_q, bus.mc_re});
        pid_d         = PW'({pid_q, gnt_id});
        hit           = pv_q[RD_LATENCY-1] & bus.mc_rvalid;
        bus.rsp_valid = NUM_REQ'(hit) << pid_q[RD_LATENCY-1];
        bus.rsp_data  = hit ? bus.mc_rdata : '0;
        err_d         = err_q | (pv_q[RD_LATENCY-1] ^ bus.mc_rvalid);
        bus.err_rsp   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= '0;
            pv_q  <= '0;
            pid_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            pv_q  <= pv_d;
            pid_q <= pid_d;
            err_q <= err_d;
        end
    end

`ifdef AUTO_POWERDOWN_EN
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [BRAM_BANKS-1:0]             pwr_q, pwr_d, wake, acc;
    logic [BRAM_BANKS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    // An access in the expiry cycle reloads the counter, so the bank stays on.
    always_comb begin
        for (int b = 0; b < BRAM_BANKS; b++) begin
            wake[b] = 1'b0;
            for (int i = 0; i < NUM_REQ; i++)
                wake[b] |= bus.req_valid[i] && (int'(bus.req_bank[i*BANK_W +: BANK_W]) == b);
            acc[b]   = gnt_vld && (int'(gnt_bank) == b);
            pwr_d[b] = pwr_q[b];
            cnt_d[b] = cnt_q[b];
            if (!pwr_q[b]) begin
                if (wake[b]) begin
                    pwr_d[b] = 1'b1;
                    cnt_d[b] = CNT_W'(IDLE_TIMEOUT);
                end
            end else if (acc[b])
                cnt_d[b] = CNT_W'(IDLE_TIMEOUT);
            else if (cnt_q[b] == '0)
                pwr_d[b] = 1'b0;
            else
                cnt_d[b] = cnt_q[b] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_q <= '0;
            cnt_q <= '0;
        end else begin
            pwr_q <= pwr_d;
            cnt_q <= cnt_d;
        end
    end

    assign pwr = pwr_q;
`else
    assign pwr = '1;
`endif

    assign bus.bank_power_en = pwr;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: table-driven, directed and random checks of mem_req_arbiter
// against a 2-cycle memory_controller model and a cycle-scheduled response scoreboard.
module tb_mem_req_arbiter;
    localparam int NR = 4, NB = 19, BW = 5, AW = 10, DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_REQ(NR), .BRAM_BANKS(NB), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_req_arbiter #(
        .NUM_REQ(NR), .BRAM_BANKS(NB), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW),
        .RD_LATENCY(2), .IDLE_TIMEOUT(256)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // memory_controller model: 2-cycle read latency, out-of-range banks read 0
    logic [DW-1:0] mem [NB][64];
    logic          p1_v, p2_v, drop;
    logic [DW-1:0] p1_d, p2_d;

    function automatic logic [DW-1:0] rd(input logic [BW-1:0] b, input logic [AW-1:0] a);
        return (int'(b) < NB && int'(a) < 64) ? mem[b][a[5:0]] : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_d <= '0;
            p2_d <= '0;
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < 64; a++)
                    mem[b][a] <= DW'(b * 7 + a * 3 + 1);
        end else begin
            if (bus.mc_we && int'(bus.mc_bank) < NB && int'(bus.mc_addr) < 64)
                mem[bus.mc_bank][bus.mc_addr[5:0]] <= bus.mc_wdata;
            p1_v <= bus.mc_re;
            p1_d <= rd(bus.mc_bank, bus.mc_addr);
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end
    assign bus.mc_rvalid = p2_v & ~drop;
    assign bus.mc_rdata  = p2_d;

    int total = 0, bad = 0, ptr = 0, cyc = 0, last_g = -1;
    logic          exp_err = 1'b0;
    logic          sv [4];
    int            sid [4];
    logic [DW-1:0] sd [4];
    logic [NR-1:0] v = '0, w = '0;
    logic [BW-1:0] bk [NR];
    logic [AW-1:0] ad [NR];
    logic [DW-1:0] wd [NR];

    typedef struct {
        logic [NR-1:0] v;
        logic [NR-1:0] w;
        int            g;
    } row_t;
    row_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = v;
        bus.req_we    = w;
        for (int i = 0; i < NR; i++) begin
            bus.req_bank[i*BW +: BW]  = bk[i];
            bus.req_addr[i*AW +: AW]  = ad[i];
            bus.req_wdata[i*DW +: DW] = wd[i];
        end
    endtask

    // One clock: eg = expected grant (-1 none), or -2 to take it from the round-robin rule.
    task automatic step(input int eg);
        int g, s, t;
        @(negedge clk);
        drive();
        #1;
        g = eg;
        if (eg == -2) begin
            g = -1;
            for (int k = 0; k < NR && g < 0; k++)
                if (v[(ptr + k) % NR]) g = (ptr + k) % NR;
        end
        chk("ready", bus.req_ready, g < 0 ? 0 : 1 << g);
        chk("mc_re", bus.mc_re, g >= 0 && !w[g]);
        chk("mc_we", bus.mc_we, g >= 0 && w[g]);
        chk("mc_bank", bus.mc_bank, g < 0 ? 0 : bk[g]);
        chk("mc_addr", bus.mc_addr, g < 0 ? 0 : ad[g]);
        chk("mc_wdata", bus.mc_wdata, g < 0 ? 0 : wd[g]);
        s = cyc % 4;
        chk("rsp_valid", bus.rsp_valid, (sv[s] && !drop) ? 1 << sid[s] : 0);
        chk("rsp_data", bus.rsp_data, (sv[s] && !drop) ? sd[s] : 0);
        chk("err_rsp", bus.err_rsp, exp_err);
        if (sv[s] && drop) exp_err = 1'b1;
        t = (cyc + 2) % 4;
        sv[t]  = g >= 0 && !w[g];
        sid[t] = g;
        sd[t]  = g >= 0 ? rd(bk[g], ad[g]) : '0;
        if (g >= 0) ptr = (g + 1) % NR;
        last_g = g;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive();
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_mc", {bus.mc_we, bus.mc_re, bus.mc_bank, bus.mc_addr, bus.mc_wdata}, 0);
        chk("rst_err", bus.err_rsp, 0);
`ifdef AUTO_POWERDOWN_EN
        chk("rst_pwr", bus.bank_power_en, 0);
`else
        chk("rst_pwr", bus.bank_power_en, {NB{1'b1}});
`endif
        repeat (2) @(negedge clk);
        v = '0;
        drive();
        drop = 1'b0;
        exp_err = 1'b0;
        ptr = 0;
        for (int i = 0; i < 4; i++) sv[i] = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        drop = 1'b0;
        for (int i = 0; i < 4; i++) sv[i] = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bk[i] = '0;
            ad[i] = '0;
            wd[i] = '0;
        end
        do_reset();

        // reset in the middle of an outstanding read: nothing comes back
        v = 4'b0001; w = '0; bk[0] = 5'd20; ad[0] = 10'd3;
        step(0);
        do_reset();
        repeat (4) step(-1);

        // out-of-range bank passes through, reads 0; a missing rvalid sets err_rsp
        v = 4'b0100; w = '0; bk[2] = 5'd20; ad[2] = 10'd5;
        step(2);
        v = '0;
        step(-1);
        step(-1);
        chk("t6_rsp", {bus.rsp_valid, bus.rsp_data}, {4'b0100, 8'h00});
        step(-1);
        v = 4'b0100;
        step(2);
        v = '0;
        step(-1);
        drop = 1'b1;
        step(-1);
        step(-1);
        drop = 1'b0;
        chk("t6_err", bus.err_rsp, 1);
        step(-1);
        do_reset();
        chk("t6_err_cleared", bus.err_rsp, 0);

`ifndef AUTO_POWERDOWN_EN
        // round-robin order from a table; every requester keeps issuing new requests
        tbl[0] = '{4'b1111, 4'b0000, 0};
        tbl[1] = '{4'b1111, 4'b0000, 1};
        tbl[2] = '{4'b1111, 4'b0000, 2};
        tbl[3] = '{4'b1111, 4'b0000, 3};
        tbl[4] = '{4'b1111, 4'b0000, 0};
        tbl[5] = '{4'b0101, 4'b0000, 2};
        tbl[6] = '{4'b0101, 4'b0001, 0};
        tbl[7] = '{4'b0000, 4'b0000, -1};
        tbl[8] = '{4'b1000, 4'b0000, 3};
        for (int i = 0; i < NR; i++) begin
            bk[i] = 5'd2;
            ad[i] = AW'(i);
            wd[i] = 8'h3C;
        end
        for (int r = 0; r < 9; r++) begin
            v = tbl[r].v;
            w = tbl[r].w;
            step(tbl[r].g);
        end
        v = '0; w = '0;
        repeat (3) step(-1);

        // write then read back through requester 1
        v = 4'b0010; w = 4'b0010; bk[1] = 5'd3; ad[1] = 10'h010; wd[1] = 8'hA5;
        step(1);
        w = '0;
        step(1);
        v = '0;
        step(-1);
        step(-1);
        chk("t3_rsp", {bus.rsp_valid, bus.rsp_data}, {4'b0010, 8'hA5});
        step(-1);

        // random traffic against the round-robin rule and the response scoreboard
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i]  = 1'b1;
                    w[i]  = 1'($urandom_range(0, 1));
                    bk[i] = BW'($urandom_range(0, 21));
                    ad[i] = AW'($urandom_range(0, 63));
                    wd[i] = DW'($urandom);
                end
            end
            step(-2);
            if (last_g >= 0) begin
                v[last_g] = 1'($urandom_range(0, 1));
                w[last_g] = 1'($urandom_range(0, 1));
                bk[last_g] = BW'($urandom_range(0, 21));
                ad[last_g] = AW'($urandom_range(0, 63));
                wd[last_g] = DW'($urandom);
            end
        end
        v = '0;
        repeat (3) step(-1);
        chk("rnd_err", bus.err_rsp, 0);
`else
        // wake on demand, idle expiry, and access on the expiry cycle
        v = 4'b0001; w = '0; bk[0] = 5'd5; ad[0] = 10'd1;
        step(-1);
        chk("t4_off_first", bus.bank_power_en[5], 0);
        step(0);
        chk("t4_woken", bus.bank_power_en[5], 1);
        v = '0;
        for (int n = 1; n <= 256; n++) step(-1);
        chk("t4_still_on", bus.bank_power_en[5], 1);
        v = 4'b0001;
        step(0);
        v = '0;
        for (int n = 1; n <= 257; n++) step(-1);
        chk("t4_kept_on", bus.bank_power_en[5], 1);
        step(-1);
        chk("t4_expired", bus.bank_power_en[5], 0);
        v = 4'b0001;
        step(-1);
        step(0);
        v = '0;
        repeat (3) step(-1);

        // a powered bank is served while another wakes
        do_reset();
        v = 4'b0010; bk[1] = 5'd0; ad[1] = 10'd7;
        step(-1);
        step(1);
        v = 4'b0011; bk[0] = 5'd4; ad[0] = 10'd2;
        step(1);
        step(0);
        chk("t5_pwr4", bus.bank_power_en[4], 1);
        v = '0;
        repeat (3) step(-1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
